// File: rtl/bit_serializer.sv
// ============================================================================
//  Module   : bit_serializer
//  Brief    : Parallel-to-serial converter with a one-entry pending buffer,
//             valid/ready input handshake and a hold input that stalls output.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             hold_i,
    output logic             d_o,
    output logic             valid_o,
    output logic             word_done_o,
    output logic             busy_o
);

    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_shift;
    logic [c_CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]     r_pend;
    logic                 r_pend_valid;
    logic                 r_d;
    logic                 r_valid;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_emit;
    logic                 w_last;
    logic                 w_load_direct;
    logic                 w_next_bit;
    logic [WIDTH-1:0]     w_shifted;

    // Bit ordering is fixed at elaboration; the shifter always drains from one end.
    if (MSB_FIRST) begin : g_msb_first
        assign w_next_bit = r_shift[WIDTH-1];
        assign w_shifted  = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
        assign w_next_bit = r_shift[0];
        assign w_shifted  = {1'b0, r_shift[WIDTH-1:1]};
    end

    assign ready_o  = ~rst & ~r_pend_valid;
    assign w_accept = valid_i & ready_o;
    assign w_emit   = (r_state == ST_SHIFT) & ~hold_i;
    assign w_last   = w_emit & (r_count == c_ONE);

    // A word bypasses the pending buffer whenever the shifter frees up at this edge.
    assign w_load_direct = w_accept &
                           ((r_state == ST_IDLE) | (w_last & ~r_pend_valid));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_count      <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_d          <= 1'b0;
            r_valid      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            if (w_emit) begin
                r_d     <= w_next_bit;
                r_valid <= 1'b1;
                r_done  <= w_last;
                if (w_last) begin
                    if (r_pend_valid) begin
                        r_shift      <= r_pend;
                        r_count      <= c_FULL;
                        r_pend_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_shift <= data_i;
                        r_count <= c_FULL;
                    end else begin
                        r_state <= ST_IDLE;
                        r_shift <= '0;
                        r_count <= '0;
                    end
                end else begin
                    r_shift <= w_shifted;
                    r_count <= r_count - c_ONE;
                end
            end else begin
                // Idle or held: shifter and counter stay frozen.
                r_d     <= 1'b0;
                r_valid <= 1'b0;
                r_done  <= 1'b0;
                if ((r_state == ST_IDLE) && w_accept) begin
                    r_shift <= data_i;
                    r_count <= c_FULL;
                    r_state <= ST_SHIFT;
                end
            end

            if (w_accept && !w_load_direct) begin
                r_pend       <= data_i;
                r_pend_valid <= 1'b1;
            end
        end
    end

    assign d_o         = r_d;
    assign valid_o     = r_valid;
    assign word_done_o = r_done;
    assign busy_o      = (r_state == ST_SHIFT) | r_pend_valid;

endmodule

`default_nettype wire
